// File: rtl/debug_controller_pkg.sv
// Shared definitions for the debug run-control unit: FSM state encodings,
// stop-cause codes, the default halt opcode and a width helper for the
// breakpoint index.
package debug_controller_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_STEP    = 2'd2
  } state_e;

  // Codes 5..7 are reserved and never produced.
  typedef enum logic [2:0] {
    CAUSE_RESET  = 3'd0,
    CAUSE_HALTOP = 3'd1,
    CAUSE_BP     = 3'd2,
    CAUSE_EXT    = 3'd3,
    CAUSE_STEP   = 3'd4
  } cause_e;

  localparam logic [4:0] DEFAULT_HALT_OPCODE = 5'b11111;

  // Index width for n breakpoint slots; a single slot still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debug_controller_bp_match.sv
// Breakpoint comparator array. Compares the current PC against every enabled
// slot and reports whether any matched plus the lowest matching slot index.
module debug_controller_bp_match
  import debug_controller_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int NUM_BP = 2,
  localparam int IDX_W = idx_width(NUM_BP)
) (
  input  logic [ADDR_W-1:0]        pc,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  output logic                     hit,
  output logic [IDX_W-1:0]         idx
);

  // Scan from the highest slot down so the lowest matching slot is the last
  // one written and therefore wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (pc == bp_addr[i*ADDR_W +: ADDR_W])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/debug_controller.sv
// Run-control unit for the MIPS8 core. Gates the PC write-enable and supports
// free run, N-instruction step, external halt, halt-opcode stop and address
// breakpoints. Reports the stop cause and a saturating retired count.
module debug_controller
  import debug_controller_pkg::*;
#(
  parameter int                  OPCODE_W    = 5,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = DEFAULT_HALT_OPCODE,
  parameter int                  ADDR_W      = 8,
  parameter int                  NUM_BP      = 2,
  parameter int                  STEP_W      = 8,
  localparam int                 IDX_W       = idx_width(NUM_BP)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     step_req,
  input  logic [STEP_W-1:0]        step_count,
  input  logic                     halt_req,
  input  logic [OPCODE_W-1:0]      opcode,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  output logic                     pc_enabled,
  output logic                     stopped,
  output logic [2:0]               halt_cause,
  output logic [IDX_W-1:0]         bp_hit_idx,
  output logic [STEP_W-1:0]        retired
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   remaining_q, remaining_d;
  logic                bp_mask_q, bp_mask_d;
  logic [STEP_W-1:0]   retired_q, retired_d;
  cause_e              cause_q, cause_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic                bp_hit;
  logic [IDX_W-1:0]    bp_idx;
  logic                active;
  logic                stop_ext;
  logic                stop_op;
  logic                stop_bp;
  logic                stop_cond;
  cause_e              stop_cause;
  logic [STEP_W-1:0]   step_load;

  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  debug_controller_bp_match #(
    .ADDR_W (ADDR_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .pc      (pc),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .hit     (bp_hit),
    .idx     (bp_idx)
  );

  // Stop detection and PC gating; only meaningful while executing.
  always_comb begin
    active     = (state_q != ST_STOPPED);
    stop_ext   = halt_req;
    stop_op    = (opcode == HALT_OPCODE);
    stop_bp    = bp_hit && !bp_mask_q;
    stop_cond  = active && (stop_ext || stop_op || stop_bp);
    pc_enabled = active && !stop_cond;
    stop_cause = CAUSE_BP;
    if (stop_ext) begin
      stop_cause = CAUSE_EXT;
    end else if (stop_op) begin
      stop_cause = CAUSE_HALTOP;
    end
    step_load  = (step_count == '0) ? STEP_W'(1) : step_count;
  end

  // Next-state logic for the FSM, step counter, breakpoint mask, retired
  // counter and the latched stop cause / breakpoint slot.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    bp_mask_d   = bp_mask_q;
    retired_d   = retired_q;
    cause_d     = cause_q;
    idx_d       = idx_q;

    unique case (state_q)
      ST_STOPPED: begin
        // Entering execution masks the breakpoint at the resume PC for one
        // cycle so a breakpoint stop can be stepped past.
        if (start) begin
          state_d   = ST_RUN;
          retired_d = '0;
          bp_mask_d = 1'b1;
        end else if (step_req) begin
          state_d     = ST_STEP;
          remaining_d = step_load;
          retired_d   = '0;
          bp_mask_d   = 1'b1;
        end
      end

      ST_RUN, ST_STEP: begin
        bp_mask_d = 1'b0;
        if (pc_enabled) begin
          retired_d = sat_inc(retired_q);
        end
        if (stop_cond) begin
          state_d = ST_STOPPED;
          cause_d = stop_cause;
          if (stop_cause == CAUSE_BP) begin
            idx_d = bp_idx;
          end
        end else if (state_q == ST_STEP) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == STEP_W'(1)) begin
            state_d = ST_STOPPED;
            cause_d = CAUSE_STEP;
          end
        end
      end

      default: begin
        state_d = ST_STOPPED;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_STOPPED;
      remaining_q <= '0;
      bp_mask_q   <= 1'b0;
      retired_q   <= '0;
      cause_q     <= CAUSE_RESET;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      bp_mask_q   <= bp_mask_d;
      retired_q   <= retired_d;
      cause_q     <= cause_d;
      idx_q       <= idx_d;
    end
  end

  assign stopped    = (state_q == ST_STOPPED);
  assign halt_cause = cause_q;
  assign bp_hit_idx = idx_q;
  assign retired    = retired_q;

endmodule
